// File: rtl/pla_rom_scan_ctrl.sv
// Scan sequencer for the 6-in/48-out PLA ROM: walks an address range, streams
// (address, word) pairs through a 2-entry valid/ready buffer and folds every
// delivered word into a 48-bit rotate-XOR signature.
//
// Handshake: an entry moves downstream on a cycle where out_valid && out_ready
// at the rising edge; out_addr/out_data hold steady while out_valid && !out_ready.
module pla_rom_scan_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [6:0]        count,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] signature,
  output logic [1:0]        dbg_state
);

  localparam int ENT_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [6:0]          rem_q, rem_d;
  logic [DATA_W-1:0]   sig_q, sig_d;
  logic                done_q, done_d;

  logic [ENT_W-1:0]    mem_q [2];
  logic                wr_q, rd_q;
  logic [1:0]          occ_q;

  logic                push, pop;
  logic [6:0]          count_clamped;
  logic [ENT_W-1:0]    head;

  assign head          = mem_q[rd_q];
  assign out_valid     = (occ_q != 2'd0);
  assign out_addr      = head[ENT_W-1:DATA_W];
  assign out_data      = head[DATA_W-1:0];
  assign rom_addr      = addr_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign signature     = sig_q;
  assign dbg_state     = state_q;
  assign count_clamped = (count > 7'd64) ? 7'd64 : count;

  // Abort discards the cycle's transfers so the signature holds its value.
  assign pop  = out_valid && out_ready && !abort;
  assign push = (state_q == RUN) && !abort && ((occ_q != 2'd2) || pop);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    sig_d   = pop ? ({sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ out_data) : sig_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          addr_d = start_addr;
          rem_d  = count_clamped;
          sig_d  = '0;
          if (count_clamped == 7'd0) done_d  = 1'b1;
          else                       state_d = RUN;
        end
      end
      RUN: begin
        if (push) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 7'd1;
          if (rem_q == 7'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Empty once the pop happening this cycle (if any) is counted.
        if (occ_q == {1'b0, pop}) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      sig_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      sig_q   <= sig_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      occ_q    <= 2'd0;
    end else if (abort) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= {addr_q, rom_data};
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
